ps2_rx_fifo: RTL



---
 rtl/ps2_rx_fifo_if.sv | 21 ++
 rtl/ps2_rx_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: pin-side and consumer-side signals of the PS/2 receiver.
// master = keyboard pins plus scan-code consumer; slave = the receiver itself.
interface ps2_rx_fifo_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       nextdata_n;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       frame_err;

   modport master (
      output ps2_clk, ps2_data, nextdata_n,
      input  data, ready, overflow, frame_err
   );

   modport slave (
      input  ps2_clk, ps2_data, nextdata_n,
      output data, ready, overflow, frame_err
   );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host frame receiver feeding a scan-code FIFO.
// Frames are start(0), 8 data bits LSB first, odd parity, stop(1), sampled on
// the synchronised falling edge of ps2_clk. Valid bytes are queued and popped
// by a falling edge on nextdata_n.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames with bad parity.
module ps2_rx_fifo #(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic         clk,
   input  logic         rst,
   ps2_rx_fifo_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

`ifdef PS2_PARITY_CHECK_EN
   localparam bit PARITY_CHECK = 1'b1;
`else
   localparam bit PARITY_CHECK = 1'b0;
`endif

   // Pin synchronisers
   logic [2:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          fe;
   logic          bit_in;

   // Frame receiver
   logic [1:0]    state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          parity_bit;
   logic          parity_ok;
   logic          frame_ok;
   logic          push_req;
   logic          frame_err_q;
   logic [TW-1:0] idle_cnt;
   logic          timeout;

   // Pop handshake
   logic          nd_cur;
   logic          nd_prev;
   logic          pop;

   // FIFO
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          do_push;
   logic [7:0]    data_q;
   logic          ready_q;
   logic          overflow_q;

   assign fe        = ~clk_sync[1] & clk_sync[2];
   assign bit_in    = data_sync[1];
   assign timeout   = (idle_cnt == TW'(TIMEOUT_CYCLES)) && (state != S_IDLE);
   assign parity_ok = ^{shift, parity_bit};
   assign frame_ok  = bit_in & (parity_ok | ~PARITY_CHECK);

   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign pop       = nd_prev & ~nd_cur & ready_q & (count != '0);
   // A push into a full FIFO only succeeds when a pop frees a slot in the same cycle.
   assign do_push   = push_req & (~full | pop);

   assign bus.data      = data_q;
   assign bus.ready     = ready_q;
   assign bus.overflow  = overflow_q;
   assign bus.frame_err = frame_err_q;

   // Bring the asynchronous PS/2 pins into the clk domain (idle-high lines).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync  <= '1;
         data_sync <= '1;
      end else begin
         // NOTE: non-blocking so every stage captures its predecessor's pre-edge value.
         clk_sync  <= {clk_sync[1:0], bus.ps2_clk};
         data_sync <= {data_sync[0], bus.ps2_data};
      end
   end

   // Cycles since the last PS/2 falling edge, saturating at the timeout limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt <= '0;
      end else if (fe) begin
         idle_cnt <= '0;
      end else if (idle_cnt != TW'(TIMEOUT_CYCLES)) begin
         idle_cnt <= idle_cnt + TW'(1);
      end
   end

   // Frame state machine: one step per falling edge, abort on a stalled frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         bit_cnt     <= '0;
         shift       <= '0;
         parity_bit  <= 1'b0;
         push_req    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         push_req    <= 1'b0;
         frame_err_q <= 1'b0;
         if (fe) begin
            case (state)
               S_IDLE: begin
                  if (!bit_in) begin
                     state   <= S_DATA;
                     bit_cnt <= '0;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end
               S_DATA: begin
                  shift   <= {bit_in, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= S_PARITY;
               end
               S_PARITY: begin
                  parity_bit <= bit_in;
                  state      <= S_STOP;
               end
               S_STOP: begin
                  if (frame_ok) push_req    <= 1'b1;
                  else          frame_err_q <= 1'b1;
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end else if (timeout) begin
            state       <= S_IDLE;
            frame_err_q <= 1'b1;
         end
      end
   end

   // Two-stage register on the pop request so a held-low level pops only once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nd_cur  <= 1'b1;
         nd_prev <= 1'b1;
      end else begin
         nd_cur  <= bus.nextdata_n;
         nd_prev <= nd_cur;
      end
   end

   // Byte storage; the shift register still holds the accepted byte one cycle after the stop bit.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; count and pointers define which entries are valid.
      if (do_push) mem[wr_ptr] <= shift;
   end

   // FIFO pointers, occupancy, sticky overflow and registered head outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
         ready_q    <= 1'b0;
         data_q     <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (pop)                   overflow_q <= 1'b0;
         else if (push_req && full) overflow_q <= 1'b1;
         ready_q <= (count != '0);
         if (count != '0) data_q <= mem[rd_ptr];
      end
   end
endmodule
